parity_frame_serializer: RTL and testbench

Parallel-to-serial transmitter that sits directly upstream of the serial parity checker. It accepts a `DATA_W`-bit word over a valid/ready handshake and drives it LSB-first onto the single-bit line `x`, followed by one generated parity bit and an idle gap. The downstream checker's running parity therefore returns to a known value at every frame boundary. This stage produces the exact bit stream the checker consumes.

---
 rtl/parity_frame_serializer_pkg.sv | 19 +
 rtl/parity_frame_serializer.sv | 125 ++++++++++++
 tb/tb_parity_frame_serializer.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/parity_frame_serializer_pkg.sv
// Shared definitions for the parity frame serializer.
//   state_e         : frame FSM state encoding (2 bits)
//   DEF_DATA_W      : default data bits per frame
//   DEF_GAP_CYCLES  : default idle cycles after the parity bit
//   DEF_PARITY_ODD  : default parity sense (0 = even, 1 = odd)
package parity_ser_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2,
    GAP  = 2'd3
  } state_e;

  localparam int DEF_DATA_W     = 8;
  localparam int DEF_GAP_CYCLES = 1;
  localparam bit DEF_PARITY_ODD = 1'b0;

endpackage

// File: rtl/parity_frame_serializer.sv
// Parallel-to-serial frame transmitter feeding the serial parity checker.
// A word accepted over valid/ready is sent LSB-first on x, followed by one
// parity bit and GAP_CYCLES idle zeros.
//
// Ports:
//   clk        : clock, rising edge
//   reset      : synchronous active-high reset
//   in_data    : word to transmit
//   in_valid   : in_data is valid
//   in_ready   : word accepted this cycle if in_valid is high (IDLE, not in reset)
//   x          : registered serial output
//   busy       : registered, frame in progress (data, parity or gap)
//   frame_done : registered one-cycle pulse while x carries the parity bit
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | x=0, waiting for a handshake
// DATA  | x carries data bits, LSB first
// PAR   | x carries the parity bit, frame_done high
// GAP   | x=0 for GAP_CYCLES cycles before returning to IDLE
module parity_frame_serializer
  import parity_ser_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES,
  parameter bit PARITY_ODD = DEF_PARITY_ODD
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              x,
  output logic              busy,
  output logic              frame_done
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_e            state;
  logic [DATA_W-1:0] shreg;
  logic              par;
  logic [CNT_W-1:0]  bitcnt;
  logic [GAP_W-1:0]  gapcnt;

  assign in_ready = (state == IDLE) && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      shreg      <= '0;
      par        <= 1'b0;
      bitcnt     <= '0;
      gapcnt     <= '0;
      x          <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          x          <= 1'b0;
          busy       <= 1'b0;
          frame_done <= 1'b0;
          if (in_valid && in_ready) begin
            // x is registered, so bit 0 is launched straight from in_data at
            // the handshake edge; the shift register holds the remaining bits.
            x      <= in_data[0];
            shreg  <= in_data >> 1;
            par    <= (^in_data) ^ PARITY_ODD;
            bitcnt <= '0;
            busy   <= 1'b1;
            state  <= DATA;
          end
        end

        DATA: begin
          // bitcnt indexes the bit currently on x
          if (bitcnt == LAST_BIT) begin
            x          <= par;
            frame_done <= 1'b1;
            state      <= PAR;
          end else begin
            x      <= shreg[0];
            shreg  <= shreg >> 1;
            bitcnt <= bitcnt + CNT_W'(1);
          end
        end

        PAR: begin
          x          <= 1'b0;
          frame_done <= 1'b0;
          if (GAP_CYCLES > 0) begin
            gapcnt <= GAP_LOAD;
            state  <= GAP;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        GAP: begin
          x <= 1'b0;
          // down-counter: terminal count zero ends the gap
          if (gapcnt == '0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            gapcnt <= gapcnt - GAP_W'(1);
          end
        end

        default: begin
          x          <= 1'b0;
          busy       <= 1'b0;
          frame_done <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_parity_frame_serializer.sv
// Directed bench for parity_frame_serializer. Three instances: even and odd
// parity with 8-bit words and one gap cycle (sharing stimulus), and a 1-bit,
// no-gap corner instance. Running parity of x is tracked per frame to play
// the role of the downstream checker.
module tb_parity_frame_serializer;
  import parity_ser_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       rdy_e, x_e, busy_e, fd_e;
  logic       rdy_o, x_o, busy_o, fd_o;
  logic [0:0] in_data1;
  logic       in_valid1;
  logic       rdy_w, x_w, busy_w, fd_w;

  int tests = 0;
  int fails = 0;
  logic acc_e, acc_o;

  always #5 clk = ~clk;

  parity_frame_serializer #(.DATA_W(8), .GAP_CYCLES(1), .PARITY_ODD(1'b0)) dut_e (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy_e), .x(x_e), .busy(busy_e), .frame_done(fd_e));

  parity_frame_serializer #(.DATA_W(8), .GAP_CYCLES(1), .PARITY_ODD(1'b1)) dut_o (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy_o), .x(x_o), .busy(busy_o), .frame_done(fd_o));

  parity_frame_serializer #(.DATA_W(1), .GAP_CYCLES(0), .PARITY_ODD(1'b0)) dut_w (
    .clk(clk), .reset(reset), .in_data(in_data1), .in_valid(in_valid1),
    .in_ready(rdy_w), .x(x_w), .busy(busy_w), .frame_done(fd_w));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance one edge, then sample/drive 1 time unit later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called during cycle N+1 after a handshake at edge N. Checks the data
  // bits, parity bit and gap on both 8-bit instances and leaves the bench
  // in the first IDLE cycle after the frame.
  task automatic frame_body(input logic [7:0] d, input logic pe, input logic po);
    acc_e = 1'b0;
    acc_o = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("data_e_bit%0d", k), x_e, d[k]);
      chk($sformatf("data_o_bit%0d", k), x_o, d[k]);
      chk("busy_data", busy_e, 1'b1);
      chk("fd_data", fd_e, 1'b0);
      chk("rdy_data", rdy_e, 1'b0);
      acc_e ^= x_e;
      acc_o ^= x_o;
      tick();
    end
    chk("par_e", x_e, pe);
    chk("par_o", x_o, po);
    chk("fd_e_par", fd_e, 1'b1);
    chk("fd_o_par", fd_o, 1'b1);
    acc_e ^= x_e;
    acc_o ^= x_o;
    tick();
    chk("gap_x_e", x_e, 1'b0);
    chk("gap_fd_e", fd_e, 1'b0);
    chk("gap_busy_e", busy_e, 1'b1);
    acc_e ^= x_e;
    acc_o ^= x_o;
    tick();
    chk("idle_busy_e", busy_e, 1'b0);
    chk("idle_rdy_e", rdy_e, 1'b1);
    chk("idle_x_e", x_e, 1'b0);
    chk("checker_even", acc_e, 1'b0);
    chk("checker_odd", acc_o, 1'b1);
  endtask

  task automatic frame8(input logic [7:0] d, input logic pe, input logic po);
    in_data  = d;
    in_valid = 1'b1;
    chk("rdy_before_hs", rdy_e, 1'b1);
    tick();
    in_valid = 1'b0;
    frame_body(d, pe, po);
  endtask

  initial begin
    reset     = 1'b1;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    in_data1  = 1'b0;
    in_valid1 = 1'b0;

    // reset held for two cycles
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_x", x_e, 1'b0);
      chk("rst_rdy", rdy_e, 1'b0);
      chk("rst_busy", busy_e, 1'b0);
      chk("rst_fd", fd_e, 1'b0);
      chk("rst_rdy_w", rdy_w, 1'b0);
    end
    reset = 1'b0;
    #1;
    chk("rdy_after_rst", rdy_e, 1'b1);
    chk("rdy_after_rst_w", rdy_w, 1'b1);
    tick();

    // A5: 4 ones -> even parity 0, odd parity 1
    frame8(8'hA5, 1'b0, 1'b1);
    // 07: 3 ones -> even parity 1, odd parity 0
    frame8(8'h07, 1'b1, 1'b0);

    // in_valid held high: FF then 01, data toggled mid-frame
    in_data  = 8'hFF;
    in_valid = 1'b1;
    tick();
    for (int i = 1; i <= 10; i++) begin
      chk($sformatf("b2b_rdy_c%0d", i), rdy_e, 1'b0);
      if (i <= 8) chk($sformatf("b2b_ff_bit%0d", i - 1), x_e, 1'b1);
      in_data = (i == 10) ? 8'h01 : 8'(i * 37);
      tick();
    end
    chk("b2b_rdy_c11", rdy_e, 1'b1);
    chk("b2b_busy_c11", busy_e, 1'b0);
    tick();
    in_valid = 1'b0;
    in_data  = 8'h5A;
    // 01: 1 one -> even parity 1, odd parity 0
    frame_body(8'h01, 1'b1, 1'b0);

    // reset after three data bits of F0
    in_data  = 8'hF0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("f0_bit", x_e, 1'b0);
      chk("f0_busy", busy_e, 1'b1);
      tick();
    end
    reset = 1'b1;
    tick();
    chk("abort_state_e", dut_e.state, IDLE);
    chk("abort_state_o", dut_o.state, IDLE);
    chk("abort_x", x_e, 1'b0);
    chk("abort_busy", busy_e, 1'b0);
    chk("abort_fd", fd_e, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("post_abort_fd_e", fd_e, 1'b0);
      chk("post_abort_fd_o", fd_o, 1'b0);
      chk("post_abort_x", x_e, 1'b0);
      tick();
    end
    // 3C: 4 ones -> even parity 0, odd parity 1
    frame8(8'h3C, 1'b0, 1'b1);

    // DATA_W=1, GAP_CYCLES=0, back-to-back 1'b1
    in_data1  = 1'b1;
    in_valid1 = 1'b1;
    chk("w1_rdy0", rdy_w, 1'b1);
    tick();
    chk("w1_data", x_w, 1'b1);
    chk("w1_busy", busy_w, 1'b1);
    chk("w1_fd_data", fd_w, 1'b0);
    chk("w1_rdy_data", rdy_w, 1'b0);
    tick();
    chk("w1_par", x_w, 1'b1);
    chk("w1_fd_par", fd_w, 1'b1);
    chk("w1_rdy_par", rdy_w, 1'b0);
    tick();
    chk("w1_idle_x", x_w, 1'b0);
    chk("w1_idle_busy", busy_w, 1'b0);
    chk("w1_idle_fd", fd_w, 1'b0);
    chk("w1_idle_rdy", rdy_w, 1'b1);
    tick();
    in_valid1 = 1'b0;
    chk("w1_second_data", x_w, 1'b1);
    chk("w1_second_busy", busy_w, 1'b1);
    tick();
    tick();
    tick();
    chk("w1_end_busy", busy_w, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
